// File: rtl/ap_mon_pkg.sv
// Shared types, readout codes and the saturating-increment helper for ap_status_monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ap_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_t;

  // rd_sel encoding
  localparam logic [2:0] SEL_START    = 3'd0;
  localparam logic [2:0] SEL_DONE     = 3'd1;
  localparam logic [2:0] SEL_BUSY     = 3'd2;
  localparam logic [2:0] SEL_STALL    = 3'd3;
  localparam logic [2:0] SEL_READY    = 3'd4;
  localparam logic [2:0] SEL_LAT_MAX  = 3'd5;
  localparam logic [2:0] SEL_LAT_LAST = 3'd6;

  // Widest counter the helper can handle; callers cast to their own width.
  localparam int MAX_CNT_W = 64;

  // Increment v, treating the low w bits as the counter; sticks at all-ones.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] v,
                                                   input int w);
    logic [MAX_CNT_W-1:0] top;
    top = {MAX_CNT_W{1'b1}} >> (MAX_CNT_W - w);
    return (v == top) ? v : v + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ap_ch_monitor.sv
// One ap_ctrl_hs channel: IDLE/RUN/HOLD tracker, saturating statistics, sticky protocol error.
// Latency: counters and state update on the clock edge that samples the handshake.
// Backpressure: none; observe-only, hold=1 freezes every register.
// Ports: clock, reset (sync, active-low), hold, ap_start/ap_ready/ap_done/ap_continue,
//        statistic counters out, proto_err out. Latency registers (lat_max, lat_last)
//        exist only when AP_STATUS_MON_LATENCY_EN is defined.
module ap_ch_monitor
  import ap_mon_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             hold,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] busy_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] ready_cnt,
`ifdef AP_STATUS_MON_LATENCY_EN
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] lat_last,
`endif
  output logic             proto_err
);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(MAX_CNT_W'(v), CNT_W));
  endfunction

  ch_state_t state, state_nxt;
  logic      start_q;     // ap_start of the previous cycle, to spot a falling edge
  logic      ready_seen;  // ap_ready observed since the current RUN entry
  logic      inc_start;
  logic      inc_done;
  logic      err_nxt;

  always_comb begin
    state_nxt = state;
    inc_start = 1'b0;
    inc_done  = 1'b0;
    err_nxt   = proto_err;
    case (state)
      IDLE: begin
        if (ap_done) err_nxt = 1'b1;
        if (ap_start) begin
          state_nxt = RUN;
          inc_start = 1'b1;
        end
      end
      RUN: begin
        // ap_start withdrawn before the kernel acknowledged it with ap_ready
        if (start_q && !ap_start && !(ready_seen || ap_ready)) err_nxt = 1'b1;
        if (ap_done && ap_continue) begin
          inc_done = 1'b1;
          if (ap_start) inc_start = 1'b1;
          else          state_nxt = IDLE;
        end else if (ap_done) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // ap_done was already captured on the way into HOLD; ap_continue completes it
        if (ap_continue) begin
          inc_done = 1'b1;
          if (ap_start) begin
            state_nxt = RUN;
            inc_start = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      ready_seen <= 1'b0;
      proto_err  <= 1'b0;
      start_cnt  <= '0;
      done_cnt   <= '0;
      busy_cnt   <= '0;
      stall_cnt  <= '0;
      ready_cnt  <= '0;
    end else if (!hold) begin
      state     <= state_nxt;
      start_q   <= ap_start;
      proto_err <= err_nxt;
      if (inc_start)        ready_seen <= ap_ready;
      else if (state == RUN) ready_seen <= ready_seen | ap_ready;
      if (inc_start)       start_cnt <= inc(start_cnt);
      if (inc_done)        done_cnt  <= inc(done_cnt);
      if (state == RUN)    busy_cnt  <= inc(busy_cnt);
      if (state == HOLD)   stall_cnt <= inc(stall_cnt);
      if (ap_ready)        ready_cnt <= inc(ready_cnt);
    end
  end

`ifdef AP_STATUS_MON_LATENCY_EN
  // lat_cur counts the cycles already spent since (and including) the start cycle;
  // the done cycle itself is added by lat_fin.
  logic [CNT_W-1:0] lat_cur;
  logic [CNT_W-1:0] lat_fin;

  assign lat_fin = inc(lat_cur);

  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_cur  <= '0;
      lat_max  <= '0;
      lat_last <= '0;
    end else if (!hold) begin
      if (inc_done) begin
        lat_last <= lat_fin;
        if (lat_fin > lat_max) lat_max <= lat_fin;
      end
      if (inc_start)          lat_cur <= CNT_W'(1);
      else if (state != IDLE) lat_cur <= lat_fin;
    end
  end
`endif

endmodule

// File: rtl/ap_status_monitor.sv
// Multi-channel ap_ctrl_hs status monitor: per-channel statistics, freeze and register readout.
// Latency: readout returns 1 cycle after rd_en with values sampled in the rd_en cycle.
// Backpressure: none; rd_en is accepted every cycle, rd_valid is a single-cycle pulse.
// Ports: clock, reset (sync, active-low); ap_start/ap_ready/ap_done/ap_continue [NUM_CH];
//        finish (freeze), rd_en/rd_ch/rd_sel in; rd_valid/rd_data/rd_err, frozen, proto_err out.
// Option: define AP_STATUS_MON_LATENCY_EN to add per-channel LAT_MAX / LAT_LAST statistics.
module ap_status_monitor
  import ap_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              rd_en,
  input  logic [3:0]        rd_ch,
  input  logic [2:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_err,
  output logic              frozen,
  output logic [NUM_CH-1:0] proto_err
);

  logic [CNT_W-1:0] start_cnt [NUM_CH];
  logic [CNT_W-1:0] done_cnt  [NUM_CH];
  logic [CNT_W-1:0] busy_cnt  [NUM_CH];
  logic [CNT_W-1:0] stall_cnt [NUM_CH];
  logic [CNT_W-1:0] ready_cnt [NUM_CH];
`ifdef AP_STATUS_MON_LATENCY_EN
  logic [CNT_W-1:0] lat_max   [NUM_CH];
  logic [CNT_W-1:0] lat_last  [NUM_CH];
`endif

  // The edge that first sees finish must already hold, so finish gates directly.
  logic hold;
  assign hold = frozen | finish;

  always_ff @(posedge clock) begin
    if (!reset)      frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    ap_ch_monitor #(.CNT_W(CNT_W)) u_ch (
      .clock       (clock),
      .reset       (reset),
      .hold        (hold),
      .ap_start    (ap_start[ch]),
      .ap_ready    (ap_ready[ch]),
      .ap_done     (ap_done[ch]),
      .ap_continue (ap_continue[ch]),
      .start_cnt   (start_cnt[ch]),
      .done_cnt    (done_cnt[ch]),
      .busy_cnt    (busy_cnt[ch]),
      .stall_cnt   (stall_cnt[ch]),
      .ready_cnt   (ready_cnt[ch]),
`ifdef AP_STATUS_MON_LATENCY_EN
      .lat_max     (lat_max[ch]),
      .lat_last    (lat_last[ch]),
`endif
      .proto_err   (proto_err[ch])
    );
  end

  // Readout mux; an unmatched channel or unused code leaves data at 0 with error set.
  logic [CNT_W-1:0] sel_dat;
  logic             sel_err;

  always_comb begin
    sel_dat = '0;
    sel_err = 1'b1;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_ch == 4'(ch)) begin
        sel_err = 1'b0;
        case (rd_sel)
          SEL_START:    sel_dat = start_cnt[ch];
          SEL_DONE:     sel_dat = done_cnt[ch];
          SEL_BUSY:     sel_dat = busy_cnt[ch];
          SEL_STALL:    sel_dat = stall_cnt[ch];
          SEL_READY:    sel_dat = ready_cnt[ch];
`ifdef AP_STATUS_MON_LATENCY_EN
          SEL_LAT_MAX:  sel_dat = lat_max[ch];
          SEL_LAT_LAST: sel_dat = lat_last[ch];
`endif
          default:      sel_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & sel_err;
      rd_data  <= rd_en ? sel_dat : '0;
    end
  end

endmodule

// File: tb/tb_ap_status_monitor.sv
module tb_ap_status_monitor;
  import ap_mon_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [NUM_CH-1:0] ap_start = '0;
  logic [NUM_CH-1:0] ap_ready = '0;
  logic [NUM_CH-1:0] ap_done = '0;
  logic [NUM_CH-1:0] ap_continue = '1;
  logic              finish = 1'b0;
  logic              rd_en = 1'b0;
  logic [3:0]        rd_ch = '0;
  logic [2:0]        rd_sel = '0;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_err;
  logic              frozen;
  logic [NUM_CH-1:0] proto_err;

  always #5 clock = ~clock;

  ap_status_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .finish      (finish),
    .rd_en       (rd_en),
    .rd_ch       (rd_ch),
    .rd_sel      (rd_sel),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .frozen      (frozen),
    .proto_err   (proto_err)
  );

  typedef struct {
    int               ch;
    int               sel;
    logic [CNT_W-1:0] dat;
    logic             err;
    int               cyc;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one readout and queue what it must return one cycle later.
  task automatic rd(input int ch, input int sel, input int val);
    rd_exp_t e;
    logic    err;
    err = (ch >= NUM_CH) || (sel == 7);
`ifndef AP_STATUS_MON_LATENCY_EN
    if (sel >= 5) err = 1'b1;
`endif
    e.ch  = ch;
    e.sel = sel;
    e.err = err;
    e.dat = err ? '0 : CNT_W'(val);
    e.cyc = cyc;
    sb.push_back(e);
    rd_en  = 1'b1;
    rd_ch  = 4'(ch);
    rd_sel = 3'(sel);
    tick();
    rd_en  = 1'b0;
  endtask

  always @(negedge clock) begin
    rd_exp_t e;
    logic    exp_vld;
    exp_vld = (sb.size() > 0) && (sb[0].cyc + 1 == cyc);
    check("rd_valid", 64'(rd_valid), 64'(exp_vld));
    if (exp_vld) begin
      e = sb.pop_front();
      check($sformatf("rd_data ch%0d sel%0d", e.ch, e.sel), 64'(rd_data), 64'(e.dat));
      check($sformatf("rd_err ch%0d sel%0d", e.ch, e.sel), 64'(rd_err), 64'(e.err));
    end else if (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("reset frozen", 64'(frozen), 64'(0));
    check("reset proto_err", 64'(proto_err), 64'(0));
    check("reset state ch0", 64'(dut.g_ch[0].u_ch.state), 64'(IDLE));
    reset = 1'b1;
    tick();
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 7; s++) rd(c, s, 0);

    // ch0: single transaction, 4 RUN cycles, latency 5
    ap_start[0] = 1'b1; ap_ready[0] = 1'b1; tick();
    ap_start[0] = 1'b0; ap_ready[0] = 1'b0;
    repeat (3) tick();
    ap_done[0] = 1'b1; tick();
    ap_done[0] = 1'b0;
    check("ch0 state after done", 64'(dut.g_ch[0].u_ch.state), 64'(IDLE));
    rd(0, 0, 1); rd(0, 1, 1); rd(0, 2, 4); rd(0, 3, 0); rd(0, 4, 1);
    rd(0, 5, 5); rd(0, 6, 5);

    // ch1: done without continue, 3 HOLD cycles
    ap_start[1] = 1'b1; ap_ready[1] = 1'b1; tick();
    ap_start[1] = 1'b0; ap_ready[1] = 1'b0; tick();
    ap_done[1] = 1'b1; ap_continue[1] = 1'b0; tick();
    ap_done[1] = 1'b0;
    check("ch1 state hold", 64'(dut.g_ch[1].u_ch.state), 64'(HOLD));
    repeat (2) tick();
    ap_continue[1] = 1'b1; tick();
    check("ch1 state idle", 64'(dut.g_ch[1].u_ch.state), 64'(IDLE));
    rd(1, 3, 3); rd(1, 1, 1); rd(1, 0, 1); rd(1, 2, 2); rd(1, 6, 6);
    check("proto_err clean", 64'(proto_err), 64'(0));

    // ch2: three back-to-back done+start handshakes
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick();
    tick();
    ap_done[2] = 1'b1; repeat (3) tick();
    ap_done[2] = 1'b0; ap_start[2] = 1'b0; ap_ready[2] = 1'b0; tick();
    check("ch2 state run", 64'(dut.g_ch[2].u_ch.state), 64'(RUN));
    rd(2, 2, 5);  // BUSY updates on this edge; pre-update value returned
    rd(2, 0, 4); rd(2, 1, 3); rd(2, 4, 5); rd(2, 5, 3); rd(2, 6, 2);
    ap_done[2] = 1'b1; tick();
    ap_done[2] = 1'b0;

    // ch3: long RUN saturates the 4-bit counters
    ap_start[3] = 1'b1; ap_ready[3] = 1'b1; tick();
    ap_start[3] = 1'b0; ap_ready[3] = 1'b0;
    repeat (20) tick();
    rd(3, 2, 15);
    ap_done[3] = 1'b1; tick();
    ap_done[3] = 1'b0;
    rd(3, 2, 15); rd(3, 1, 1); rd(3, 6, 15); rd(3, 5, 15);

    // protocol errors: done in IDLE (ch0), start dropped before ready (ch1)
    ap_done[0] = 1'b1; tick();
    ap_done[0] = 1'b0; tick();
    check("proto_err ch0 set", 64'(proto_err), 64'(4'b0001));
    tick();
    check("proto_err ch0 sticky", 64'(proto_err), 64'(4'b0001));
    ap_start[1] = 1'b1; tick();
    ap_start[1] = 1'b0; tick();
    check("proto_err ch1 set", 64'(proto_err), 64'(4'b0011));

    // freeze with ch1 still in RUN
    finish = 1'b1; tick();
    finish = 1'b0;
    check("frozen set", 64'(frozen), 64'(1));
    rd(1, 2, 3); rd(1, 0, 2);
    ap_start[0] = 1'b1; ap_ready = '1;
    repeat (10) tick();
    rd(1, 2, 3); rd(0, 0, 1); rd(0, 4, 1); rd(0, 1, 1);
    ap_start[0] = 1'b0; ap_ready = '0;
    check("frozen sticky", 64'(frozen), 64'(1));
    check("proto_err frozen", 64'(proto_err), 64'(4'b0011));
    check("ch0 state frozen", 64'(dut.g_ch[0].u_ch.state), 64'(IDLE));

    // readout errors
    rd(NUM_CH, 0, 0);
    rd(0, 7, 0);

    // reset pulse in the middle of a ch2 transaction
    reset = 1'b0; tick();
    reset = 1'b1;
    ap_start[2] = 1'b1; ap_ready[2] = 1'b1; tick();
    ap_start[2] = 1'b0; ap_ready[2] = 1'b0;
    repeat (2) tick();
    check("ch2 run before reset", 64'(dut.g_ch[2].u_ch.state), 64'(RUN));
    reset = 1'b0; tick();
    reset = 1'b1;
    check("ch2 idle after reset", 64'(dut.g_ch[2].u_ch.state), 64'(IDLE));
    check("frozen after reset", 64'(frozen), 64'(0));
    check("proto_err after reset", 64'(proto_err), 64'(0));
    for (int c = 0; c < NUM_CH; c++)
      for (int s = 0; s < 7; s++) rd(c, s, 0);

    repeat (4) tick();
    check("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
